// File: rtl/osc_bcd_pkg.sv
// Shared types and helpers for the iterative binary-to-BCD converter.
// Holds the FSM state type, the BCD nine constant and a digit-count helper.
package osc_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  localparam logic [3:0] BCD_NINE = 4'h9;

  // Decimal digits needed to print 2^width-1.
  function automatic int bcd_digits_for(input int width);
    longint unsigned v;
    int              n;
    v = (64'd1 << width) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Shift-and-add-3 digit correction: adds 3 to a BCD digit of 5 or more.
// Purely combinational, zero latency, no flow control.
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter with sign, saturation and digit count.
// done arrives BIN_W+1 cycles after start is presented; start is ignored while busy.
module bin2bcd_seq
  import osc_bcd_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        signed_mode,
  input  logic [BIN_W-1:0]            bindata,
  output logic                        ready,
  output logic                        done,
  output logic [4*DIGITS-1:0]         decimalout,
  output logic                        negative,
  output logic                        overflow,
  output logic [$clog2(DIGITS+1)-1:0] ndigits
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int ND_W  = $clog2(DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] MAG_ONE = BIN_W'(1);

  if (DIGITS < 1 || BIN_W < 2) begin : g_bad_param
    $error("bin2bcd_seq: DIGITS must be >= 1 and BIN_W >= 2");
  end
  if (DIGITS < bcd_digits_for(BIN_W)) begin : g_ovf_reachable
    $info("bin2bcd_seq warning: DIGITS too small for BIN_W, overflow is reachable");
  end

  bcd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] mag_q, mag_d;
  logic [BCD_W-1:0] acc_q, acc_d, acc_adj, acc_sh;
  logic             ovf_q, ovf_d, ovf_sh;
  logic             neg_q, neg_d;
  logic [BCD_W-1:0] dec_q, dec_d;
  logic             negative_q, negative_d;
  logic             overflow_q, overflow_d;
  logic [ND_W-1:0]  ndig_q, ndig_d, ndig_sh;
  logic             done_q, done_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (acc_q[4*g +: 4]),
      .digit_out (acc_adj[4*g +: 4])
    );
  end

  // One double-dabble step; the bit falling off the top digit means >= 10^DIGITS.
  always_comb begin
    acc_sh  = {acc_adj[BCD_W-2:0], mag_q[BIN_W-1]};
    ovf_sh  = ovf_q | acc_adj[BCD_W-1];
    ndig_sh = ND_W'(1);
    for (int i = 1; i < DIGITS; i++) begin
      if (acc_sh[4*i +: 4] != 4'h0) ndig_sh = ND_W'(i + 1);
    end
    if (ovf_sh) ndig_sh = ND_W'(DIGITS);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    neg_d      = neg_q;
    dec_d      = dec_q;
    negative_d = negative_q;
    overflow_d = overflow_q;
    ndig_d     = ndig_q;
    done_d     = 1'b0;
    case (state_q)
      SHIFT: begin
        acc_d = acc_sh;
        mag_d = {mag_q[BIN_W-2:0], 1'b0};
        ovf_d = ovf_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d    = DONE;
          done_d     = 1'b1;
          dec_d      = ovf_sh ? {DIGITS{BCD_NINE}} : acc_sh;
          negative_d = neg_q;
          overflow_d = ovf_sh;
          ndig_d     = ndig_sh;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          // A set sign bit means a nonzero value, so -0 cannot be produced.
          neg_d   = signed_mode & bindata[BIN_W-1];
          mag_d   = neg_d ? (~bindata + MAG_ONE) : bindata;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
      dec_q      <= '0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      ndig_q     <= ND_W'(1);
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      neg_q      <= neg_d;
      dec_q      <= dec_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
      ndig_q     <= ndig_d;
      done_q     <= done_d;
    end
  end

  assign ready      = (state_q != SHIFT);
  assign done       = done_q;
  assign decimalout = dec_q;
  assign negative   = negative_q;
  assign overflow   = overflow_q;
  assign ndigits    = ndig_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 6-digit and a 3-digit converter share stimulus,
// a division-based cycle model is compared every cycle, plus literal pins.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [11:0] bindata = '0;

  always #5 clk = ~clk;

  logic        r6, d6, n6, o6;
  logic [23:0] dec6;
  logic [2:0]  nd6;
  logic        r3, d3, n3, o3;
  logic [11:0] dec3;
  logic [1:0]  nd3;

  bin2bcd_seq #(.BIN_W(12), .DIGITS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .bindata(bindata), .ready(r6), .done(d6), .decimalout(dec6),
    .negative(n6), .overflow(o6), .ndigits(nd6)
  );

  bin2bcd_seq #(.BIN_W(12), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .bindata(bindata), .ready(r3), .done(d3), .decimalout(dec3),
    .negative(n3), .overflow(o3), .ndigits(nd3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Reference conversion by plain integer arithmetic.
  function automatic void ref_conv(input logic [11:0] data, input logic sgn, input int d,
                                   output logic [23:0] dec, output logic neg,
                                   output logic ovf, output int nd);
    longint mag, lim, t;
    if (sgn && data[11]) begin
      mag = 64'd4096 - longint'(data);
      neg = 1'b1;
    end else begin
      mag = longint'(data);
      neg = 1'b0;
    end
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    ovf = (mag >= lim);
    dec = '0;
    if (ovf) begin
      for (int i = 0; i < d; i++) dec[4*i +: 4] = 4'h9;
      nd = d;
    end else begin
      t = mag;
      for (int i = 0; i < d; i++) begin
        dec[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      nd = 1;
      t  = mag / 10;
      while (t > 0) begin
        nd++;
        t = t / 10;
      end
    end
  endfunction

  // Cycle model: a conversion accepted at edge a completes at edge a+12.
  int          edge_n = 0;
  bit          pend = 1'b0;
  int          due = 0;
  logic [23:0] p_dec [2];
  logic        p_neg [2];
  logic        p_ovf [2];
  int          p_nd  [2];
  logic [23:0] e_dec [2] = '{24'h0, 24'h0};
  logic        e_neg [2] = '{1'b0, 1'b0};
  logic        e_ovf [2] = '{1'b0, 1'b0};
  int          e_nd  [2] = '{1, 1};
  bit          e_done = 1'b0;
  bit          e_ready = 1'b1;

  always @(posedge clk) begin
    bit acc_ok;
    edge_n++;
    if (!rst_n) begin
      pend   = 1'b0;
      e_done = 1'b0;
      for (int k = 0; k < 2; k++) begin
        e_dec[k] = '0; e_neg[k] = 1'b0; e_ovf[k] = 1'b0; e_nd[k] = 1;
      end
    end else begin
      acc_ok = !pend;
      e_done = 1'b0;
      if (pend && edge_n == due) begin
        for (int k = 0; k < 2; k++) begin
          e_dec[k] = p_dec[k]; e_neg[k] = p_neg[k]; e_ovf[k] = p_ovf[k]; e_nd[k] = p_nd[k];
        end
        e_done = 1'b1;
        pend   = 1'b0;
      end
      if (acc_ok && start) begin
        pend = 1'b1;
        due  = edge_n + 12;
        ref_conv(bindata, signed_mode, 6, p_dec[0], p_neg[0], p_ovf[0], p_nd[0]);
        ref_conv(bindata, signed_mode, 3, p_dec[1], p_neg[1], p_ovf[1], p_nd[1]);
      end
    end
    e_ready = !pend;
  end

  always @(negedge clk) begin
    if (edge_n > 0) begin
      chk("d6_ready", r6, e_ready);
      chk("d6_done", d6, e_done);
      chk("d6_dec", dec6, e_dec[0]);
      chk("d6_neg", n6, e_neg[0]);
      chk("d6_ovf", o6, e_ovf[0]);
      chk("d6_nd", nd6, e_nd[0]);
      chk("d3_ready", r3, e_ready);
      chk("d3_done", d3, e_done);
      chk("d3_dec", dec3, e_dec[1][11:0]);
      chk("d3_neg", n3, e_neg[1]);
      chk("d3_ovf", o3, e_ovf[1]);
      chk("d3_nd", nd3, e_nd[1]);
    end
  end

  // Entered and left on a falling edge; returns cycles from start to done.
  task automatic run(input logic [11:0] data, input logic sgn, output int lat);
    start = 1'b1; bindata = data; signed_mode = sgn;
    @(negedge clk);
    start = 1'b0; bindata = ~data; signed_mode = ~sgn;
    lat = 1;
    while (!d6 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!d6) chk("done_timeout", d6, 1);
  endtask

  initial begin
    int lat, cnt, p0, p1, p2;
    logic [23:0] dec_at;

    repeat (3) @(negedge clk);
    chk("rst_ready", r6, 1); chk("rst_done", d6, 0); chk("rst_dec", dec6, 24'h0);
    chk("rst_nd", nd6, 1); chk("rst_neg", n6, 0); chk("rst_ovf", o6, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(12'd4095, 1'b0, lat);
    chk("lat_4095", lat, 13); chk("u4095_dec", dec6, 24'h004095);
    chk("u4095_nd", nd6, 4); chk("u4095_ovf", o6, 0);
    chk("u4095_d3_dec", dec3, 12'h999); chk("u4095_d3_ovf", o3, 1); chk("u4095_d3_nd", nd3, 3);
    run(12'd0, 1'b0, lat);
    chk("u0_dec", dec6, 24'h0); chk("u0_nd", nd6, 1);
    run(12'h800, 1'b1, lat);
    chk("s800_dec", dec6, 24'h002048); chk("s800_neg", n6, 1); chk("s800_nd", nd6, 4);
    run(12'hFFF, 1'b1, lat);
    chk("sFFF_dec", dec6, 24'h000001); chk("sFFF_neg", n6, 1); chk("sFFF_nd", nd6, 1);
    run(12'h7FF, 1'b1, lat);
    chk("s7FF_dec", dec6, 24'h002047); chk("s7FF_neg", n6, 0);
    run(12'd1000, 1'b0, lat);
    chk("o1000_dec", dec3, 12'h999); chk("o1000_ovf", o3, 1); chk("o1000_nd", nd3, 3);
    chk("o1000_d6_dec", dec6, 24'h001000);
    run(12'd999, 1'b0, lat);
    chk("o999_dec", dec3, 12'h999); chk("o999_ovf", o3, 0); chk("o999_nd", nd3, 3);

    // start held high with data changing every cycle
    cnt = 0; p0 = 0; p1 = 0; p2 = 0;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bindata = 12'(i * 97 + 5);
      signed_mode = i[0];
      @(negedge clk);
      if (d6) begin
        cnt++;
        if (cnt == 1) p0 = i;
        if (cnt == 2) p1 = i;
        if (cnt == 3) p2 = i;
      end
    end
    start = 1'b0;
    chk("b2b_pulses", cnt, 3);
    chk("b2b_gap1", p1 - p0, 13);
    chk("b2b_gap2", p2 - p1, 13);
    repeat (15) @(negedge clk);

    // start during SHIFT must be dropped
    start = 1'b1; bindata = 12'd321; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; bindata = 12'd999;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; dec_at = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (d6) begin
        cnt++;
        dec_at = dec6;
      end
    end
    chk("ign_pulses", cnt, 1);
    chk("ign_dec", dec_at, 24'h000321);

    // reset in the middle of a conversion
    start = 1'b1; bindata = 12'd777; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_ready", r6, 1); chk("mrst_done", d6, 0); chk("mrst_dec", dec6, 24'h0);
    chk("mrst_nd", nd6, 1); chk("mrst_neg", n6, 0); chk("mrst_ovf", o6, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d6) cnt++;
    end
    chk("mrst_no_done", cnt, 0);
    run(12'd1234, 1'b0, lat);
    chk("after_rst_dec", dec6, 24'h001234); chk("after_rst_lat", lat, 13);

    // random sweep, start held high, model checks every result
    start = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      bindata = 12'($urandom);
      signed_mode = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
